matpair_loader_2x2: RTL and testbench
=====================================

Name: matpair_loader_2x2

Overview:
- Sequential input stage placed directly upstream of the 2x2 matrix subtract/add datapath.
- Deserialises a stream of signed elements, one per cycle, into an operand pair A and B of N x N matrices.
- Presents the pair on parallel matrix ports with a valid/ready handshake, so the combinational matrix stages can be driven from a narrow bus or FIFO.

Parameters:
- BIT_PREC, 8: element width in bits, signed two's complement.
- N, 2: matrix dimension; one frame is 2*N*N elements (8 at default).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  BIT_PREC signed  stream element.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  marks the final element of a frame; qualified by in_valid.
- in_ready  output  1  block accepts an element this cycle.
- A_o  output  [BIT_PREC-1:0] signed [N][N]  assembled matrix A.
- B_o  output  [BIT_PREC-1:0] signed [N][N]  assembled matrix B.
- out_valid  output  1  A_o/B_o hold a complete pair.
- out_ready  input  1  downstream consumes the pair.
- err_o  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset, asynchronous while rst=1:
  - out_valid=0, A_o and B_o all zero, err_o=0, element counter cnt=0, state COLLECT.
  - in_ready=0 while rst is asserted.
- Element order within a frame is row-major, A then B: A[0][0], A[0][1], A[1][0], A[1][1], B[0][0], B[0][1], B[1][0], B[1][1].
  - Generally, element k goes to A[k/N][k%N] for k<N*N, otherwise to B[(k-N*N)/N][(k-N*N)%N].
- Accept condition: an element is accepted when in_valid && in_ready.
  - The element is written to slot cnt, then cnt increments.
  - Elements are stored verbatim; no arithmetic, no sign change.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- COLLECT -> HOLD: final element (cnt=2N*N-1) accepted with in_last=1.
  - out_valid rises the next cycle, so latency is 1 cycle from the last accepted element.
  - cnt returns to 0.
- HOLD -> COLLECT: on the edge where out_valid && out_ready.
  - in_ready rises the cycle after the handshake; no new element is accepted in the handshake cycle itself.
- Stability: A_o/B_o and out_valid are stable while out_valid=1 and out_ready=0.
  - A_o/B_o keep their last values after the handshake until overwritten.
- Framing errors:
  - in_last=1 on an element with cnt<2N*N-1: err_o pulses for 1 cycle, the partial frame is discarded, cnt=0 and state stays COLLECT.
  - in_last=0 on the element with cnt=2N*N-1: same response; the next accepted element starts a new frame at slot 0.
  - A discarded frame never asserts out_valid. A_o/B_o may hold partial data but are don't-care while out_valid=0.
- in_valid=0 cycles inside a frame: cnt holds. There is no timeout.
- out_ready while out_valid=0: ignored.
- Reset mid-frame or mid-HOLD: the partial frame or pending pair is lost; outputs return to reset values immediately.

Optional Feature:
- Macro: MATPAIR_LOADER_DBUF_EN.
- Defined:
  - A separate collect buffer feeds the output register, so the next frame is gathered while the current pair is held.
  - in_ready=0 only when the collect buffer holds a complete frame and the output register is still valid and not being consumed.
  - If the final element is accepted in the same cycle that the output handshake completes, the new pair loads into the output register and out_valid stays 1 with no gap.
  - Sustained throughput is one pair per 2N*N cycles.
- Undefined: single buffer, exactly as in Behaviour; in_ready=0 throughout HOLD.

Test Plan:
- Basic frame: stream 1,2,3,4,-1,-2,-3,-4 with in_last on the 8th element, out_ready=1.
  - Required: out_valid=1 exactly 1 cycle after the 8th element.
  - Required: A_o={{1,2},{3,4}}, B_o={{-1,-2},{-3,-4}}.
  - Required: out_valid drops the next cycle.
- Backpressure: same frame with out_ready=0 for 5 cycles.
  - Required: A_o/B_o/out_valid stable for all 5 cycles.
  - Required (base build): in_ready=0 throughout HOLD.
  - Required: an element offered during HOLD is not consumed.
- Gaps and extremes: elements 127,-128,0,-1,127,127,-128,-128 with in_valid low on alternate cycles.
  - Required: correct placement; out_valid 1 cycle after the last element; values unchanged.
- Framing errors:
  - in_last on the 3rd element: err_o pulses 1 cycle, no out_valid.
  - Then a clean frame 8..15: A_o={{8,9},{10,11}}.
  - 8 elements without in_last: err_o pulses, no out_valid.
- Reset mid-operation: assert rst after 5 elements.
  - Required: out_valid=0, A_o/B_o=0, in_ready=0 while rst is asserted.
  - Required: after release, a full frame produces the correct pair.
- DBUF build: two back-to-back frames with out_ready=0 until the second frame completes.
  - Required: in_ready drops after the 16th element.
  - Required: the first pair is presented, then the second pair follows with no out_valid gap when out_ready=1.

Source files
------------

// File: rtl/matpair_loader_2x2.sv
// matpair_loader_2x2: deserialises a stream of signed elements into a pair of
// N x N matrices (A then B, row-major) for the matrix add/subtract datapath.
// Handshake: in_valid/in_ready upstream, out_valid/out_ready downstream.
// err_o pulses for one cycle when the in_last position does not match the
// frame length.
//
// Optional build macro: MATPAIR_LOADER_DBUF_EN
//   When defined, a separate collect buffer gathers the next frame while the
//   output register holds the current pair. This gives one pair per 2*N*N
//   cycles.
//   When undefined, the elements are written straight into the output
//   register, and in_ready stays low while a pair is held.
module matpair_loader_2x2 #(
    parameter int unsigned BIT_PREC = 8,
    parameter int unsigned N        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [BIT_PREC-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic signed [BIT_PREC-1:0] A_o [N][N],
    output logic signed [BIT_PREC-1:0] B_o [N][N],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err_o
);

    localparam int unsigned Frame = 2 * N * N;
    localparam int unsigned CntW  = $clog2(Frame);
    localparam logic [CntW-1:0] LastSlot = CntW'(Frame - 1);

    typedef enum logic {StCollect, StHold} state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic signed [BIT_PREC-1:0] out_q [Frame];
    logic signed [BIT_PREC-1:0] out_d [Frame];

    logic accept;
    logic at_last;
    logic frame_done;
    logic frame_err;

    assign at_last    = (cnt_q == LastSlot);
    assign accept     = in_valid & in_ready;
    assign frame_done = accept & at_last & in_last;
    // A misplaced in_last, or a missing in_last on the final slot, discards the frame.
    assign frame_err  = accept & (at_last ^ in_last);
    assign out_valid  = (state_q == StHold);
    assign err_o      = err_q;

    // Element slot counter and framing-error pulse
    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (accept) begin
            cnt_d = (at_last || in_last) ? '0 : cnt_q + CntW'(1);
            err_d = frame_err;
        end
    end

    // Flat element k maps to A for k < N*N, otherwise to B, both row-major
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign A_o[r][c] = out_q[r * N + c];
            assign B_o[r][c] = out_q[N * N + r * N + c];
        end
    end

`ifdef MATPAIR_LOADER_DBUF_EN

    logic signed [BIT_PREC-1:0] col_q [Frame];
    logic signed [BIT_PREC-1:0] col_d [Frame];
    logic                       full_q, full_d;
    logic                       out_free;

    // The output register can take a new pair when it is empty or being consumed now.
    assign out_free = (state_q == StCollect) | out_ready;
    // Stall only when a whole frame is parked in the collect buffer and cannot move on.
    assign in_ready = ~rst & ~(full_q & ~out_free);

    // Collect-buffer writes and hand-off of complete frames into the output register
    always_comb begin
        col_d   = col_q;
        out_d   = out_q;
        full_d  = full_q;
        state_d = state_q;
        if (accept) begin
            col_d[cnt_q] = in_data;
        end
        if (out_valid && out_ready) begin
            state_d = StCollect;
        end
        // A parked frame implies cnt is back at 0, so frame_done cannot coincide with it.
        if (full_q && out_free) begin
            out_d   = col_q;
            full_d  = 1'b0;
            state_d = StHold;
        end else if (frame_done) begin
            if (out_free) begin
                // Bypass: the final element goes straight into the output with the rest.
                out_d   = col_d;
                state_d = StHold;
            end else begin
                full_d = 1'b1;
            end
        end
    end

    // Collect buffer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '{default: '0};
            full_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            full_q <= full_d;
        end
    end

`else

    assign in_ready = ~rst & (state_q == StCollect);

    // Single buffer: elements land directly in the output register while collecting
    always_comb begin
        out_d   = out_q;
        state_d = state_q;
        if (accept) begin
            out_d[cnt_q] = in_data;
        end
        case (state_q)
            StCollect: if (frame_done) state_d = StHold;
            StHold:    if (out_ready)  state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

`endif

    // State, counter, error pulse and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StCollect;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_matpair_loader_2x2.sv
// Testbench for matpair_loader_2x2. A queue-based reference model tracks the
// partial frame and the pairs that are still pending. Every expectation comes
// from that model or from constants.
module tb_matpair_loader_2x2;

    localparam int FR = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic signed [7:0] A_o [2][2];
    logic signed [7:0] B_o [2][2];
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              err_o;

    always #5 clk = ~clk;

    matpair_loader_2x2 #(.BIT_PREC(8), .N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .A_o       (A_o),
        .B_o       (B_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_o     (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pairs completed but not consumed, plus the partial frame
    logic [63:0] pend[$];
    logic [63:0] facc = '0;
    int          fcnt = 0;
    bit          exp_err = 1'b0;

    function automatic bit exp_in_ready();
        if (rst) return 1'b0;
`ifdef MATPAIR_LOADER_DBUF_EN
        return !(pend.size() == 2 && !out_ready);
`else
        return pend.size() == 0;
`endif
    endfunction

    function automatic logic [63:0] flat_out();
        logic [63:0] f;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                f[8*(r*2+c) +: 8]     = A_o[r][c];
                f[8*(4+r*2+c) +: 8]   = B_o[r][c];
            end
        end
        return f;
    endfunction

    function automatic logic [63:0] pack8(input logic signed [7:0] v [8]);
        logic [63:0] f;
        for (int k = 0; k < 8; k++) f[8*k +: 8] = v[k];
        return f;
    endfunction

    task automatic model_reset();
        pend.delete();
        facc    = '0;
        fcnt    = 0;
        exp_err = 1'b0;
    endtask

    // Apply inputs just after a rising edge and wait to the sampling point
    task automatic drive(input bit v, input logic signed [7:0] d, input bit l, input bit r);
        #1;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
    endtask

    // Advance the model by the coming edge, then take the edge
    task automatic tick();
        bit acc;
        bit ov;
        acc = in_valid && exp_in_ready();
        ov  = pend.size() > 0;
        if (ov && out_ready) void'(pend.pop_front());
        exp_err = 1'b0;
        if (acc) begin
            facc[8*fcnt +: 8] = in_data;
            fcnt++;
            if (in_last || fcnt == FR) begin
                if (in_last && fcnt == FR) pend.push_back(facc);
                else exp_err = 1'b1;
                fcnt = 0;
                facc = '0;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
        n_tests++; if (flat_out() !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", flat_out()); end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic signed [7:0] v [8];
        logic [63:0] exp;
        v   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, -8'sd1, -8'sd2, -8'sd3, -8'sd4};
        exp = pack8(v);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, v[i], i == 7, 1'b1);
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
        end
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b want 1", out_valid); end
        n_tests++; if (flat_out() !== exp) begin n_fail++; $display("FAIL basic_data got %h want %h", flat_out(), exp); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", err_o); end
        tick();
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        logic signed [7:0] v [8];
        logic [63:0] exp;
        bit offer;
        bit want_rdy;
`ifdef MATPAIR_LOADER_DBUF_EN
        offer    = 1'b0;
        want_rdy = 1'b1;
`else
        offer    = 1'b1;
        want_rdy = 1'b0;
`endif
        v   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, -8'sd1, -8'sd2, -8'sd3, -8'sd4};
        exp = pack8(v);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, v[i], i == 7, 1'b0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(offer, 8'sd99, 1'b0, 1'b0);
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
            n_tests++; if (flat_out() !== exp) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, flat_out(), exp); end
            n_tests++; if (in_ready !== want_rdy) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want %b", i, in_ready, want_rdy); end
            tick();
        end
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (flat_out() !== exp) begin n_fail++; $display("FAIL bp_release_data got %h want %h", flat_out(), exp); end
        tick();
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_gaps_extremes();
        logic signed [7:0] v [8];
        logic [63:0] exp;
        v   = '{8'sd127, -8'sd128, 8'sd0, -8'sd1, 8'sd127, 8'sd127, -8'sd128, -8'sd128};
        exp = pack8(v);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, v[i], i == 7, 1'b1);
            tick();
            if (i < 7) begin
                drive(1'b0, 8'sd55, 1'b1, 1'b1);
                tick();
            end
        end
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_latency got %b want 1", out_valid); end
        n_tests++; if (flat_out() !== exp) begin n_fail++; $display("FAIL gaps_data got %h want %h", flat_out(), exp); end
        tick();
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_drop got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_framing_errors();
        logic signed [7:0] v [8];
        logic [63:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(i + 1), i == 2, 1'b1);
            tick();
        end
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL early_last_err got %b want 1", err_o); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL early_last_valid got %b want 0", out_valid); end
        tick();
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL early_last_pulse got %b want 0", err_o); end
        tick();
        for (int i = 0; i < 8; i++) v[i] = 8'(8 + i);
        exp = pack8(v);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, v[i], i == 7, 1'b1);
            tick();
        end
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL recover_valid got %b want 1", out_valid); end
        n_tests++; if (flat_out() !== exp) begin n_fail++; $display("FAIL recover_data got %h want %h", flat_out(), exp); end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(20 + i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL missing_last_err got %b want 1", err_o); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL missing_last_valid got %b want 0", out_valid); end
        tick();
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL missing_last_pulse got %b want 0", err_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic signed [7:0] v [8];
        logic [63:0] exp;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom_range(1, 100)), 1'b0, 1'b1);
            tick();
        end
        #1 rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        n_tests++; if (flat_out() !== 64'h0) begin n_fail++; $display("FAIL midrst_data got %h want 0", flat_out()); end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
        exp = pack8(v);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, v[i], i == 7, 1'b1);
            tick();
        end
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL postrst_valid got %b want 1", out_valid); end
        n_tests++; if (flat_out() !== exp) begin n_fail++; $display("FAIL postrst_data got %h want %h", flat_out(), exp); end
        tick();
    endtask

    task automatic test_back_to_back();
`ifdef MATPAIR_LOADER_DBUF_EN
        logic signed [7:0] v [8];
        logic [63:0] exp1;
        logic [63:0] exp2;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) v[i] = 8'($urandom);
            if (f == 0) exp1 = pack8(v); else exp2 = pack8(v);
            for (int i = 0; i < 8; i++) begin
                drive(1'b1, v[i], i == 7, 1'b0);
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", f*8+i, in_ready); end
                tick();
            end
        end
        drive(1'b1, 8'sd55, 1'b0, 1'b0);
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got %b want 0", in_ready); end
        n_tests++; if (flat_out() !== exp1) begin n_fail++; $display("FAIL b2b_first got %h want %h", flat_out(), exp1); end
        tick();
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got %b want 1", out_valid); end
        tick();
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap got %b want 1", out_valid); end
        n_tests++; if (flat_out() !== exp2) begin n_fail++; $display("FAIL b2b_second got %h want %h", flat_out(), exp2); end
        tick();
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got %b want 0", out_valid); end
        tick();
`else
        // Single buffer: elements are offered continuously, and only the accepted ones advance
        logic signed [7:0] v [16];
        int idx;
        int budget;
        for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
        idx    = 0;
        budget = 0;
        while (idx < 16 && budget < 100) begin
            drive(1'b1, v[idx], (idx % 8) == 7, 1'b1);
            n_tests++; if (in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL b2b_in_ready got %b want %b", in_ready, exp_in_ready()); end
            n_tests++; if (out_valid !== (pend.size() > 0)) begin n_fail++; $display("FAIL b2b_valid got %b want %b", out_valid, pend.size() > 0); end
            if (pend.size() > 0) begin
                n_tests++; if (flat_out() !== pend[0]) begin n_fail++; $display("FAIL b2b_data got %h want %h", flat_out(), pend[0]); end
            end
            if (exp_in_ready()) idx++;
            tick();
            budget++;
        end
        n_tests++; if (idx != 16) begin n_fail++; $display("FAIL b2b_budget got %0d want 16", idx); end
        drive(1'b0, 8'sd0, 1'b0, 1'b1);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_last_valid got %b want 1", out_valid); end
        tick();
`endif
    endtask

    task automatic test_random();
        bit v;
        bit l;
        bit r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = $urandom_range(0, 9) < 7;
            l = (fcnt == FR - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 1) == 1;
            drive(v, 8'($urandom), l, r);
            n_tests++; if (in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL rnd_in_ready@%0d got %b want %b", cyc, in_ready, exp_in_ready()); end
            n_tests++; if (out_valid !== (pend.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d got %b want %b", cyc, out_valid, pend.size() > 0); end
            n_tests++; if (err_o !== exp_err) begin n_fail++; $display("FAIL rnd_err@%0d got %b want %b", cyc, err_o, exp_err); end
            if (pend.size() > 0) begin
                n_tests++; if (flat_out() !== pend[0]) begin n_fail++; $display("FAIL rnd_data@%0d got %h want %h", cyc, flat_out(), pend[0]); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps_extremes();
        test_framing_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
